// File: rtl/rgb_pwm_pkg.sv
// Shared constants, colour type and presets for the RGB PWM block.
// Presets are sized for the default duty width.
package rgb_pwm_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int HFOSC_HZ  = 48_000_000;

  typedef struct packed {
    logic [WIDTH_DEF-1:0] r;
    logic [WIDTH_DEF-1:0] g;
    logic [WIDTH_DEF-1:0] b;
  } colour_t;

  localparam colour_t OFF   = '{r: 8'h00, g: 8'h00, b: 8'h00};
  localparam colour_t RED   = '{r: 8'hff, g: 8'h00, b: 8'h00};
  localparam colour_t GREEN = '{r: 8'h00, g: 8'hff, b: 8'h00};
  localparam colour_t BLUE  = '{r: 8'h00, g: 8'h00, b: 8'hff};
  localparam colour_t WHITE = '{r: 8'hff, g: 8'hff, b: 8'hff};

  // Prescaler counter width; a divide of 1 still needs one (constant) bit.
  function automatic int presc_bits(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/pwm_chan.sv
// One PWM channel: active duty register, one-code fade step and output compare.
module pwm_chan #(
  parameter int WIDTH  = 8,
  parameter bit INVERT = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] cnt,
  input  logic             apply,
  input  logic             fade,
  input  logic [WIDTH-1:0] target,
  output logic             at_target,
  output logic             led
);

  logic [WIDTH-1:0] duty_reg;
  logic [WIDTH-1:0] step;
  logic [WIDTH-1:0] duty_next;
  logic             led_reg;

  // Step saturates at the target, so no wrap is possible in either direction.
  always_comb begin
    step = duty_reg;
    if (duty_reg < target) begin
      step = duty_reg + WIDTH'(1);
    end else if (duty_reg > target) begin
      step = duty_reg - WIDTH'(1);
    end
    duty_next = fade ? step : target;
  end

  assign at_target = (step == target);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_reg <= '0;
      led_reg  <= INVERT;
    end else begin
      if (apply) begin
        duty_reg <= duty_next;
      end
      led_reg <= (cnt < duty_reg) ^ INVERT;
    end
  end

  assign led = led_reg;

endmodule

// File: rtl/rgb_pwm.sv
// Three-channel PWM LED driver with a valid/ready colour request port.
// Requests are shadowed and applied only at PWM period boundaries.
module rgb_pwm
  import rgb_pwm_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int PRESC_DIV = 48,
  parameter bit INVERT    = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_r,
  input  logic [WIDTH-1:0] i_g,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_fade,
  output logic             o_led_r,
  output logic             o_led_g,
  output logic             o_led_b,
  output logic             o_period
);

  localparam int            PW         = presc_bits(PRESC_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC_DIV - 1);

  logic [PW-1:0]    presc_reg;
  logic [WIDTH-1:0] cnt_reg;
  logic             period_reg;
  logic             pending_reg;
  logic             fade_reg;
  logic [WIDTH-1:0] shadow_reg [3];
  logic             tick;
  logic             period_end;
  logic             xfer;
  logic             apply;
  logic [2:0]       done;
  logic [2:0]       led;

  assign tick       = (presc_reg == PRESC_LAST);
  assign period_end = tick && (cnt_reg == '1);
  assign o_ready    = !pending_reg;
  assign xfer       = i_valid && !pending_reg;
  assign apply      = period_end && pending_reg;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      presc_reg  <= '0;
      cnt_reg    <= '0;
      period_reg <= 1'b0;
    end else begin
      presc_reg  <= tick ? '0 : presc_reg + PW'(1);
      if (tick) begin
        cnt_reg <= cnt_reg + WIDTH'(1);
      end
      period_reg <= period_end;
    end
  end

  // A transfer can only happen while idle and an apply only while pending,
  // so the two branches never compete for pending_reg.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pending_reg <= 1'b0;
      fade_reg    <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        shadow_reg[i] <= '0;
      end
    end else if (xfer) begin
      pending_reg   <= 1'b1;
      fade_reg      <= i_fade;
      shadow_reg[0] <= i_r;
      shadow_reg[1] <= i_g;
      shadow_reg[2] <= i_b;
    end else if (apply && (!fade_reg || (&done))) begin
      pending_reg <= 1'b0;
    end
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_chan
    pwm_chan #(
      .WIDTH  (WIDTH),
      .INVERT (INVERT)
    ) u_chan (
      .clk       (i_clk),
      .rst_n     (i_rst_n),
      .cnt       (cnt_reg),
      .apply     (apply),
      .fade      (fade_reg),
      .target    (shadow_reg[gi]),
      .at_target (done[gi]),
      .led       (led[gi])
    );
  end

  assign o_led_r  = led[0];
  assign o_led_g  = led[1];
  assign o_led_b  = led[2];
  assign o_period = period_reg;

endmodule

// File: doc/rgb_pwm.md
Name: rgb_pwm

Overview:
- Three-channel PWM generator that turns RGB colour requests into LED drive pins.
- Sits between the colour/pattern logic and the O_LED_R/G/B pad outputs, clocked from the SB_HFOSC internal oscillator (48 MHz).
- Accepts colour updates over a valid/ready handshake. Updates are glitch-free: applied only at PWM period boundaries.
- Optional linear fade mode steps each channel one code per period toward its target.

Parameters:
- WIDTH, 8: duty/counter width in bits; PWM period is 2^WIDTH ticks.
- PRESC_DIV, 48: clock cycles per PWM tick (>=1); 1 means a tick every cycle.
- INVERT, 0: 1 inverts all three LED outputs for active-low pads.

Ports:
- i_clk  in  1  system clock (HFOSC).
- i_rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  colour request valid.
- o_ready  out  1  block can accept a request.
- i_r  in  WIDTH  red target duty.
- i_g  in  WIDTH  green target duty.
- i_b  in  WIDTH  blue target duty.
- i_fade  in  1  1 = fade to target, 0 = jump to target; sampled with the request.
- o_led_r  out  1  red PWM output.
- o_led_g  out  1  green PWM output.
- o_led_b  out  1  blue PWM output.
- o_period  out  1  one-cycle pulse at each PWM period end.

Behaviour:
- Reset (async assert, sync release) forces:
  - prescaler = 0, period counter = 0
  - active duties = 0, shadow registers = 0, pending = 0
  - o_led_* = INVERT, o_period = 0
  - o_ready = 1 once reset releases.
- Prescaler:
  - Counts 0..PRESC_DIV-1, then wraps.
  - tick = (presc == PRESC_DIV-1). With PRESC_DIV=1, tick is constantly 1.
- Period counter:
  - WIDTH bits, increments on tick, wraps 2^WIDTH-1 -> 0.
  - period_end = tick && cnt == 2^WIDTH-1.
  - o_period is registered: it is high the cycle after period_end.
- Outputs:
  - o_led_x registered: o_led_x <= (cnt < duty_x) XOR INVERT.
  - Duty 0 gives constant off. Duty 2^WIDTH-1 gives on for (2^WIDTH-1)/2^WIDTH of the period.
  - Comparison uses the value of cnt before increment; one clock latency.
- Handshake:
  - o_ready = !pending.
  - Transfer when i_valid && o_ready: latch i_r/i_g/i_b/i_fade into shadow, set pending.
  - i_valid without o_ready is ignored; the requester holds its data.
  - i_valid must not be required to drop after a transfer; back-to-back requests are accepted each time o_ready is 1.
- Apply at period_end while pending:
  - fade=0: active <= shadow for all channels; pending cleared.
  - fade=1: each channel with active != shadow moves by exactly 1 toward shadow (up or down); no wrap, no overshoot. pending is cleared on the period_end at which all three channels equal the target after the step.
  - Request carries fade=1 and target equals current active: pending clears at the next period_end with no change.
- Duties never change mid-period; a transfer on the same cycle as period_end is applied at the following period_end.
- Reset mid-fade or mid-period abandons all state; outputs return to reset values immediately.
- No arithmetic widening: duty/cnt are unsigned WIDTH bits; fade steps saturate at target.

Decomposition:
- Package rgb_pwm_pkg:
  - WIDTH default constant
  - HFOSC_HZ = 48_000_000
  - colour struct/typedef {r,g,b} of WIDTH bits
  - preset colour constants (OFF, RED, GREEN, BLUE, WHITE).
- One natural sub-module: pwm_chan. Per-channel active duty register, fade step logic and output compare. Instantiated three times; the top holds prescaler, counter, handshake, pending.

Test Plan:
- Reset check (WIDTH=4, PRESC_DIV=1, INVERT=0): hold i_rst_n=0 with random inputs -> all o_led_*=0, o_period=0; after release o_ready=1.
- Duty sweep: send r=0, g=8, b=15 (fade=0) -> from the period after the next boundary, per 16-cycle period red high 0 cycles, green 8, blue 15; o_period pulses every 16 cycles.
- Boundary sync: send g=4 mid-period while g=12 active -> current period still shows 12 high cycles; next period shows 4. o_ready low from transfer until the cycle after period_end.
- Fade: active r=2, send r=5 fade=1 -> red high counts over successive periods 3,4,5; pending clears at the third period_end. Reverse 5->2 gives 4,3,2.
- Backpressure: hold i_valid=1 with changing data while pending -> only the first value and the value present when o_ready returns are transferred; no lost or duplicated updates.
- Async reset mid-fade plus INVERT=1, PRESC_DIV=3: assert i_rst_n=0 between clock edges -> outputs go to 1 without waiting for a clock edge. After release, ticks occur every 3 cycles and the period is 48 cycles.
